// File: rtl/rf_wb_sched_pkg.sv
// Shared register-file constants and the one-hot select helper used by the
// RV32I write-back scheduler.
package rv32i_rf_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    // x0 is hard-wired to zero, so its select line never fires.
    function automatic logic [NREG-1:0] onehot_sel(input logic [REG_AW-1:0] addr);
        logic [NREG-1:0] sel;
        sel       = '0;
        sel[addr] = 1'b1;
        sel[0]    = 1'b0;
        return sel;
    endfunction

endpackage

// File: rtl/rf_wb_sched_if.sv
// Issue, write-back and register-file signals of the write-back scheduler.
// The master side is the pipeline/register file, the slave side the scheduler.
interface rf_wb_sched_if #(
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32
);
    import rv32i_rf_pkg::*;

    logic                       iss_vld;
    logic                       iss_rd_we;
    logic [REG_AW-1:0]          iss_rd;
    logic [REG_AW-1:0]          iss_rs1;
    logic [REG_AW-1:0]          iss_rs2;
    logic                       iss_stall;

    logic [NUM_WB-1:0]          wb_vld;
    logic [NUM_WB*REG_AW-1:0]   wb_rd;
    logic [NUM_WB*XLEN-1:0]     wb_data;
    logic [NUM_WB-1:0]          wb_rdy;

    logic [NREG-1:0]            reg_sel_rd;
    logic [XLEN-1:0]            reg_rd;
    logic [NREG-1:0]            reg_sel_rs1;
    logic [NREG-1:0]            reg_sel_rs2;
    logic [NREG-1:0]            busy_vec;

    modport master (
        output iss_vld, iss_rd_we, iss_rd, iss_rs1, iss_rs2,
        output wb_vld, wb_rd, wb_data,
        input  iss_stall, wb_rdy,
        input  reg_sel_rd, reg_rd, reg_sel_rs1, reg_sel_rs2, busy_vec
    );

    modport slave (
        input  iss_vld, iss_rd_we, iss_rd, iss_rs1, iss_rs2,
        input  wb_vld, wb_rd, wb_data,
        output iss_stall, wb_rdy,
        output reg_sel_rd, reg_rd, reg_sel_rs1, reg_sel_rs2, busy_vec
    );

endinterface

// File: rtl/rf_wb_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starting after the
// last winner; the pointer moves to the winner only when a transfer happens.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

    always_comb begin
        ptr_d = advance ? win : ptr_q;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// RV32I write-back scheduler: shares the register-file write port among
// NUM_WB sources and stalls issue on RAW/WAW hazards via a busy scoreboard.
module rf_wb_sched
    import rv32i_rf_pkg::*;
#(
    parameter int NUM_WB = 3,
    parameter int XLEN   = 32
) (
    input logic          clk,
    input logic          rst_n,
    rf_wb_sched_if.slave bus
);

    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NUM_WB-1:0] gnt;
    logic              xfer;
    logic              iss_stall;
    logic              iss_acc;
    logic [REG_AW-1:0] wb_rd_g;
    logic [XLEN-1:0]   wb_data_g;

    assign bus.reg_sel_rs1 = onehot_sel(bus.iss_rs1);
    assign bus.reg_sel_rs2 = onehot_sel(bus.iss_rs2);

    // Registered busy only: a write landing this cycle unblocks the next one.
    assign iss_stall = bus.iss_vld & (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] |
                                      (bus.iss_rd_we & busy_q[bus.iss_rd]));
    assign iss_acc   = bus.iss_vld & ~iss_stall;
    assign bus.iss_stall = iss_stall;

    rr_arbiter #(.N(NUM_WB)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.wb_vld),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign bus.wb_rdy = gnt;
    assign xfer       = |(bus.wb_vld & gnt);

    always_comb begin
        wb_rd_g   = '0;
        wb_data_g = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (gnt[i]) begin
                wb_rd_g   = bus.wb_rd[i*REG_AW +: REG_AW];
                wb_data_g = bus.wb_data[i*XLEN +: XLEN];
            end
        end
    end

    assign bus.reg_sel_rd = xfer ? onehot_sel(wb_rd_g) : '0;
    assign bus.reg_rd     = xfer ? wb_data_g : '0;

    // Clear before set, so an issue targeting a register that is being
    // written (only possible when it was not busy) leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[wb_rd_g] = 1'b0;
        end
        if (iss_acc && bus.iss_rd_we && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.busy_vec = busy_q;

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard for the RV32I register file.
- Shares the single register-file write port among NUM_WB write-back sources (ALU, load unit, CSR, ...) using round-robin arbitration with valid/ready handshakes.
- Tracks destination registers with pending writes and stalls decode issue on RAW and WAW hazards.
- Produces the one-hot rd/rs1/rs2 selects and write data that the register file consumes.

Parameters:
- NUM_WB, 3, number of write-back requesters (2..8).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iss_vld  in  1  decode presents an instruction for issue.
- iss_rd_we  in  1  issuing instruction writes rd.
- iss_rd  in  5  destination register address.
- iss_rs1  in  5  source 1 register address.
- iss_rs2  in  5  source 2 register address.
- iss_stall  out  1  issue blocked by hazard.
- wb_vld  in  NUM_WB  per-source write-back request.
- wb_rd  in  NUM_WB*5  per-source destination address, packed with source i at [5i+4:5i].
- wb_data  in  NUM_WB*XLEN  per-source write data, packed the same way.
- wb_rdy  out  NUM_WB  per-source grant, one-hot or zero.
- reg_sel_rd  out  32  one-hot write select to the register file.
- reg_rd  out  XLEN  write data to the register file.
- reg_sel_rs1  out  32  one-hot read select 1.
- reg_sel_rs2  out  32  one-hot read select 2.
- busy_vec  out  32  scoreboard state; bit 0 is always 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - busy_vec = 0.
  - Round-robin pointer = NUM_WB-1, so source 0 has top priority first.
  - Because all outputs are combinational from registered state and inputs, with wb_vld = 0 and iss_vld = 0 during reset: wb_rdy = 0, reg_sel_rd = 0, reg_rd = 0, iss_stall = 0.
- Read decode:
  - reg_sel_rs1 = onehot(iss_rs1) and reg_sel_rs2 = onehot(iss_rs2), both combinational.
  - Bit 0 is forced to 0, so x0 reads as 0.
- Hazard check:
  - iss_stall = iss_vld & (busy[iss_rs1] | busy[iss_rs2] | (iss_rd_we & busy[iss_rd])).
  - Uses registered busy only; there is no same-cycle bypass.
- Issue accept:
  - Accept condition is iss_vld & ~iss_stall.
  - If iss_rd_we and iss_rd != 0, busy[iss_rd] is set at the next edge.
  - Decode must hold its inputs stable while stalled.
- Arbitration:
  - Each cycle, at most one requester is granted, combinationally.
  - Search order starts at pointer+1 and wraps modulo NUM_WB.
  - wb_rdy[g] = 1 for the winner g; transfer occurs when wb_vld[g] & wb_rdy[g].
  - On a transfer, the pointer updates to g at the next edge. With no transfer, the pointer holds.
- Write drive:
  - On a transfer, reg_sel_rd = onehot(wb_rd[g]) with bit 0 forced to 0, and reg_rd = wb_data[g].
  - Otherwise, reg_sel_rd = 0 and reg_rd = 0.
  - The register file commits at the same edge.
- Busy clear:
  - busy[wb_rd[g]] is cleared at the same edge as the write.
  - A dependent instruction stalled in cycle N, where cycle N holds the write, issues in cycle N+1 and reads the new value.
- Boundary conditions:
  - wb_rd = 0: the requester is still granted and handshake completes; reg_sel_rd = 0 and busy is unchanged.
  - Write-back to a non-busy register: the write is performed and busy is unchanged.
  - Simultaneous set and clear of the same register (possible only via a non-busy write-back): set wins.
  - Requester drops wb_vld without a grant: permitted. The protocol requires holding, and verification flags a drop.
  - Write-back source stall: a source holds wb_vld, wb_rd and wb_data until it is granted.
  - Starvation bound: with all sources requesting, each source is granted within NUM_WB cycles.
  - Reset mid-operation: busy and pointer return to reset values immediately. In-flight write-backs are discarded by their owners, which are also reset.
- PC handling is outside this block.

Decomposition:
- Package rv32i_rf_pkg:
  - REG_AW = 5, NREG = 32.
  - Function onehot_sel(addr), returning 32 bits with bit 0 cleared.
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N]; output gnt[N]; input advance.
  - Holds the pointer register.
- Top-level contents: scoreboard, decode and write muxing.

Test Plan:
- Reset: assert rst_n = 0 mid-run with busy_vec = 0x0000_00A0 -> busy_vec = 0 asynchronously. After release, with all wb_vld high, the first grant is wb_rdy = 3'b001.
- RAW: cycle 0 issue rd = 5 (iss_rd_we = 1) -> busy_vec = 0x20 at cycle 1. Cycle 1 issue rs1 = 5 -> iss_stall = 1. Cycle 3 source 1 presents rd = 5, data 0xDEADBEEF -> wb_rdy = 3'b010, reg_sel_rd = 0x20, reg_rd = 0xDEADBEEF. Cycle 4 -> iss_stall = 0 and busy_vec = 0.
- Round-robin: all three wb_vld held high for 6 cycles with distinct rd -> grant sequence 0, 1, 2, 0, 1, 2. Then only source 2 requests -> granted the next cycle.
- WAW: busy_vec = 0x80, issue rd = 7, rs1 = rs2 = 0 -> iss_stall = 1. Write-back rd = 7 granted -> stall clears the next cycle and busy_vec = 0x80 again after the issue.
- x0: write-back rd = 0, data 0x1234 -> wb_rdy = 1, reg_sel_rd = 0, busy_vec unchanged. Issue rd = 0 with iss_rd_we -> no stall and no busy bit set. reg_sel_rs1 for rs1 = 0 equals 0.
- Non-busy write-back colliding with issue: busy_vec = 0, cycle N issue rd = 9 while source 0 writes rd = 9 -> write performed and busy_vec = 0x200 at N+1 (set wins).
